// File: rtl/ccff_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg
// Shared definitions for the configuration-chain loader:
//   - loaderState_e : loader FSM states (IDLE, LOAD, SHIFT, DONE)
//   - chainGeom_t   : number of host words per load and the bit count of a
//                     partial last word
//   - calcChainGeom : derives chainGeom_t from CHAIN_LEN and WORD_W
// ---------------------------------------------------------------------------
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } loaderState_e;

  typedef struct packed {
    int unsigned nWords;
    int unsigned remBits;
  } chainGeom_t;

  // nWords rounds up so a partial last word still counts as a word;
  // remBits == 0 means the last word is a full word.
  function automatic chainGeom_t calcChainGeom(input int unsigned chainLen,
                                               input int unsigned wordW);
    chainGeom_t geom;
    geom.nWords  = (chainLen + wordW - 1) / wordW;
    geom.remBits = chainLen % wordW;
    return geom;
  endfunction

endpackage

// File: rtl/ccff_readback_packer.sv
// ---------------------------------------------------------------------------
// ccff_readback_packer
// Packs the bits falling out of the configuration chain tail into host-width
// readback words, LSB first. A word is emitted when WORD_W bits have been
// collected, or early (zero-padded above) on the final shift of a load.
//
// Ports:
//   clk_i      : clock (the loader's prog_clk)
//   reset_i    : synchronous active-high reset
//   sample_i   : this cycle is a shift cycle; capture tail_i
//   tail_i     : serial bit leaving the chain (pre-shift value)
//   flush_i    : this shift is the last one of the load
//   rbData_o   : packed readback word (registered)
//   rbValid_o  : one-cycle pulse qualifying rbData_o
// ---------------------------------------------------------------------------
module ccff_readback_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sample_i,
  input  logic              tail_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] rbData_o,
  output logic              rbValid_o
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] packQ, packD;
  logic [WORD_W-1:0] rbDataQ, rbDataD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic              rbValidQ, rbValidD;

  // Each sampled tail bit lands at the position given by the bit counter, so
  // the first bit out of the chain ends up in bit 0. The pack register is
  // cleared whenever a word is emitted, which is what zero-pads a partial
  // final word.
  always_comb begin
    packD    = packQ;
    cntD     = cntQ;
    rbDataD  = rbDataQ;
    rbValidD = 1'b0;
    if (sample_i) begin
      packD[cntQ] = tail_i;
      if ((cntQ == CNT_W'(WORD_W - 1)) || flush_i) begin
        rbDataD  = packD;
        rbValidD = 1'b1;
        packD    = '0;
        cntD     = '0;
      end else begin
        cntD = cntQ + CNT_W'(1);
      end
    end
  end

  // Registers for the packer; the emitted word and its pulse appear the
  // cycle after the shift that completed it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      packQ    <= '0;
      cntQ     <= '0;
      rbDataQ  <= '0;
      rbValidQ <= 1'b0;
    end else begin
      packQ    <= packD;
      cntQ     <= cntD;
      rbDataQ  <= rbDataD;
      rbValidQ <= rbValidD;
    end
  end

  assign rbData_o  = rbDataQ;
  assign rbValid_o = rbValidQ;

endmodule

// File: rtl/ccff_loader.sv
// ---------------------------------------------------------------------------
// ccff_loader
// Loads the fabric configuration flip-flop chain. Host words arrive over a
// valid/ready port and are serialized LSB first onto ccff_head while
// ccff_shift_en gates prog_clk to the chain, one bit per enabled cycle.
// Exactly CHAIN_LEN bits are shifted per load, then cfg_done is raised.
// Optional readback (macro CCFF_LOADER_READBACK_EN) packs the bits leaving
// the chain at ccff_tail into words on rb_data/rb_valid.
//
// Ports:
//   prog_clk      : clock, rising edge
//   prog_reset    : synchronous active-high reset
//   cfg_start     : start a load (honoured only in IDLE or DONE)
//   cfg_data      : bitstream word, word 0 and bit 0 first
//   cfg_valid     : cfg_data valid
//   cfg_ready     : word accepted this cycle when cfg_valid is high
//   ccff_head     : serial bit into the chain
//   ccff_shift_en : chain clock enable, high on each shift cycle
//   ccff_tail     : serial bit out of the chain
//   cfg_busy      : load in progress (LOAD or SHIFT)
//   cfg_done      : load complete, held until cfg_start or reset
//   rb_data       : readback word (0 when readback is compiled out)
//   rb_valid      : readback word strobe (0 when readback is compiled out)
// ---------------------------------------------------------------------------
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam chainGeom_t  GEOM   = calcChainGeom(CHAIN_LEN, WORD_W);
  localparam int unsigned NWORDS = GEOM.nWords;
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WBIT_W = $clog2(WORD_W);
  localparam int WCNT_W = $clog2(NWORDS + 1);

  loaderState_e      stateQ, stateD;
  logic [WORD_W-1:0] shregQ, shregD;
  logic [CNT_W-1:0]  bitCntQ, bitCntD;
  logic [WBIT_W-1:0] wordBitQ, wordBitD;
  logic [WCNT_W-1:0] wordCntQ, wordCntD;
  logic              headQ, headD;
  logic              shiftEnQ, shiftEnD;
  logic              busyQ, doneQ;
  logic              finalBit, wordEnd, acceptWord;

  // finalBit marks the cycle shifting bit CHAIN_LEN-1 of the load; wordEnd
  // marks the last bit of a full word. Non-final words are always full, so a
  // word boundary before the final bit only ever happens at WORD_W-1.
  assign finalBit = (bitCntQ == CNT_W'(CHAIN_LEN - 1));
  assign wordEnd  = (wordBitQ == WBIT_W'(WORD_W - 1));

  // Ready is decoded combinationally so the next word can be taken on the
  // last bit of the current one, keeping the shift stream gap-free.
  assign cfg_ready = (stateQ == LOAD) ||
                     ((stateQ == SHIFT) && wordEnd && !finalBit &&
                      (wordCntQ < WCNT_W'(NWORDS)));
  assign acceptWord = cfg_ready && cfg_valid;

  // Next-state logic. ccff_head and ccff_shift_en are registered, so the
  // values for the coming shift cycle are prepared here: on an accept the
  // head gets data bit 0 straight away and the shift register keeps the
  // remaining bits. Outside SHIFT the head is left untouched.
  always_comb begin
    stateD   = stateQ;
    shregD   = shregQ;
    bitCntD  = bitCntQ;
    wordBitD = wordBitQ;
    wordCntD = wordCntQ;
    headD    = headQ;
    shiftEnD = 1'b0;
    case (stateQ)
      IDLE, DONE: begin
        if (cfg_start) begin
          stateD   = LOAD;
          bitCntD  = '0;
          wordBitD = '0;
          wordCntD = '0;
        end
      end
      LOAD: begin
      end
      SHIFT: begin
        bitCntD = bitCntQ + CNT_W'(1);
        if (finalBit) begin
          stateD = DONE;
        end else if (wordEnd) begin
          if (!cfg_valid) begin
            stateD = LOAD;
          end
        end else begin
          headD    = shregQ[0];
          shregD   = shregQ >> 1;
          shiftEnD = 1'b1;
          wordBitD = wordBitQ + WBIT_W'(1);
        end
      end
      default: stateD = IDLE;
    endcase
    if (acceptWord) begin
      stateD   = SHIFT;
      headD    = cfg_data[0];
      shregD   = cfg_data >> 1;
      shiftEnD = 1'b1;
      wordBitD = '0;
      wordCntD = wordCntQ + WCNT_W'(1);
    end
  end

  // State and output registers. Busy and done are decoded from the next
  // state so they line up with the state they describe.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      stateQ   <= IDLE;
      shregQ   <= '0;
      bitCntQ  <= '0;
      wordBitQ <= '0;
      wordCntQ <= '0;
      headQ    <= 1'b0;
      shiftEnQ <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      shregQ   <= shregD;
      bitCntQ  <= bitCntD;
      wordBitQ <= wordBitD;
      wordCntQ <= wordCntD;
      headQ    <= headD;
      shiftEnQ <= shiftEnD;
      busyQ    <= (stateD == LOAD) || (stateD == SHIFT);
      doneQ    <= (stateD == DONE);
    end
  end

  assign ccff_head     = headQ;
  assign ccff_shift_en = shiftEnQ;
  assign cfg_busy      = busyQ;
  assign cfg_done      = doneQ;

`ifdef CCFF_LOADER_READBACK_EN
  // The tail bit is captured on every shift cycle; the final shift flushes
  // whatever partial word has accumulated.
  ccff_readback_packer #(
    .WORD_W (WORD_W)
  ) uPacker (
    .clk_i     (prog_clk),
    .reset_i   (prog_reset),
    .sample_i  (shiftEnQ),
    .tail_i    (ccff_tail),
    .flush_i   (finalBit),
    .rbData_o  (rb_data),
    .rbValid_o (rb_valid)
  );
`else
  logic unusedTail;
  assign unusedTail = ccff_tail;
  assign rb_data    = '0;
  assign rb_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_loader
// Directed bench for ccff_loader with CHAIN_LEN=36, WORD_W=8. A behavioural
// chain model shifts on ccff_shift_en and feeds ccff_tail, so the chain
// contents after a load show the serialized stream directly.
// ---------------------------------------------------------------------------
module tb_ccff_loader;

  localparam int ChainLen = 36;
  localparam int WordW    = 8;

  logic             prog_clk = 1'b0;
  logic             prog_reset;
  logic             cfg_start;
  logic [WordW-1:0] cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             ccff_head;
  logic             ccff_shift_en;
  logic             ccff_tail;
  logic             cfg_busy;
  logic             cfg_done;
  logic [WordW-1:0] rb_data;
  logic             rb_valid;

  logic [ChainLen-1:0] chainModel;
  logic [ChainLen-1:0] preloadVal;
  logic                preloadReq;
  logic [WordW-1:0]    hostWords [5];
  logic [WordW-1:0]    rbWords [8];

  int checkCount;
  int errorCount;
  int rbCount;
  int acceptCyc;
  int firstShiftCyc;
  int doneCyc;
  int shiftCount;
  int gapCount;
  logic firstHead;

  ccff_loader #(
    .CHAIN_LEN (ChainLen),
    .WORD_W    (WordW)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .cfg_start     (cfg_start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: the bit entering at the head moves toward the tail by one
  // position per enabled clock, and tail is the oldest bit.
  always @(posedge prog_clk) begin
    if (preloadReq) begin
      chainModel <= preloadVal;
    end else if (ccff_shift_en) begin
      chainModel <= {ccff_head, chainModel[ChainLen-1:1]};
    end
  end

  assign ccff_tail = chainModel[0];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic preloadChain(input logic [ChainLen-1:0] value);
    preloadVal = value;
    preloadReq = 1'b1;
    @(negedge prog_clk);
    preloadReq = 1'b0;
  endtask

  // Runs one load from a cfg_start pulse. Outputs are observed on falling
  // edges; cycle numbers count falling edges after the one where the loader
  // is first seen in LOAD.
  task automatic applyStimulus(input int stallWord, input int stallLen,
                               input int pokeAt, input int abortAt);
    int idx;
    int stallLeft;
    int lastShiftCyc;
    logic willAccept;
    idx = 0;
    stallLeft = stallLen;
    acceptCyc = -1;
    firstShiftCyc = -1;
    lastShiftCyc = -1;
    doneCyc = -1;
    shiftCount = 0;
    gapCount = 0;
    rbCount = 0;
    firstHead = 1'b0;
    cfg_valid = 1'b0;
    cfg_start = 1'b1;
    @(negedge prog_clk);
    cfg_start = 1'b0;
    checkOutput("startReady", cfg_ready, 1);
    checkOutput("startBusy", cfg_busy, 1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (rb_valid) begin
        if (rbCount < 8) rbWords[rbCount] = rb_data;
        rbCount++;
      end
      if (cfg_done) begin
        doneCyc = cyc;
        break;
      end
      if (ccff_shift_en) begin
        if (firstShiftCyc < 0) begin
          firstShiftCyc = cyc;
          firstHead = ccff_head;
        end else if (cyc != lastShiftCyc + 1) begin
          gapCount += cyc - lastShiftCyc - 1;
        end
        lastShiftCyc = cyc;
        shiftCount++;
      end
      if (abortAt >= 0 && shiftCount == abortAt) break;
      cfg_start = (cyc == pokeAt);
      cfg_data  = (idx < 5) ? hostWords[idx] : '0;
      cfg_valid = (idx < 5);
      if (idx == stallWord && stallLeft > 0 && cfg_ready) begin
        cfg_valid = 1'b0;
        stallLeft--;
      end
      willAccept = cfg_ready && cfg_valid;
      @(negedge prog_clk);
      if (willAccept) begin
        if (acceptCyc < 0) acceptCyc = cyc;
        idx++;
      end
    end
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "Ready"}, cfg_ready, 0);
    checkOutput({tag, "Head"}, ccff_head, 0);
    checkOutput({tag, "ShiftEn"}, ccff_shift_en, 0);
    checkOutput({tag, "Busy"}, cfg_busy, 0);
    checkOutput({tag, "Done"}, cfg_done, 0);
    checkOutput({tag, "RbValid"}, rb_valid, 0);
    checkOutput({tag, "RbData"}, rb_data, 0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    prog_reset = 1'b1;
    cfg_start  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    preloadReq = 1'b0;
    preloadVal = '0;
    $display("[TB] reset");
    repeat (2) @(negedge prog_clk);
    checkIdleOutputs("reset");
    prog_reset = 1'b0;

    // Load 1: partial last word, valid always high, chain preloaded for readback
    $display("[TB] load with partial last word");
    preloadChain(36'h9_00_FF_3C_A5);
    hostWords = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    applyStimulus(-1, 0, -1, -1);
    checkOutput("l1Accept", acceptCyc, 0);
    checkOutput("l1FirstShift", firstShiftCyc, 1);
    checkOutput("l1FirstHead", firstHead, 1);
    checkOutput("l1Shifts", shiftCount, 36);
    checkOutput("l1Gaps", gapCount, 0);
    checkOutput("l1Done", doneCyc, 37);
    checkOutput("l1Stream", chainModel, 36'h5_04_03_02_01);
`ifdef CCFF_LOADER_READBACK_EN
    checkOutput("rbCount", rbCount, 5);
    checkOutput("rbWord0", rbWords[0], 8'hA5);
    checkOutput("rbWord1", rbWords[1], 8'h3C);
    checkOutput("rbWord2", rbWords[2], 8'hFF);
    checkOutput("rbWord3", rbWords[3], 8'h00);
    checkOutput("rbWord4", rbWords[4], 8'h09);
`else
    checkOutput("rbNone", rbCount, 0);
`endif
    repeat (3) @(negedge prog_clk);
    checkOutput("doneHold", cfg_done, 1);
    checkOutput("doneBusy", cfg_busy, 0);
    checkOutput("doneReady", cfg_ready, 0);
    checkOutput("doneShiftEn", ccff_shift_en, 0);

    // Load 2: host stalls five cycles before word 2
    $display("[TB] host stall");
    preloadChain('0);
    applyStimulus(2, 5, -1, -1);
    checkOutput("l2Shifts", shiftCount, 36);
    checkOutput("l2Gaps", gapCount, 5);
    checkOutput("l2Done", doneCyc, 42);
    checkOutput("l2Stream", chainModel, 36'h5_04_03_02_01);

    // Load 3: cfg_start pulsed mid-shift, upper nibble of last word ignored
    $display("[TB] start while busy");
    hostWords = '{8'hFF, 8'h80, 8'h7E, 8'h11, 8'hFA};
    applyStimulus(-1, 0, 10, -1);
    checkOutput("l3Shifts", shiftCount, 36);
    checkOutput("l3Gaps", gapCount, 0);
    checkOutput("l3Done", doneCyc, 37);
    checkOutput("l3Stream", chainModel, 36'hA_11_7E_80_FF);
    checkOutput("l3HeadHold", ccff_head, 1);

    // Load 4: reset after 13 shifts, then a full reload from IDLE
    $display("[TB] reset mid-load");
    hostWords = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    applyStimulus(-1, 0, -1, 13);
    checkOutput("l4Shifts", shiftCount, 13);
    prog_reset = 1'b1;
    @(negedge prog_clk);
    checkIdleOutputs("midReset");
    prog_reset = 1'b0;
    @(negedge prog_clk);
    applyStimulus(-1, 0, -1, -1);
    checkOutput("l5Shifts", shiftCount, 36);
    checkOutput("l5Done", doneCyc, 37);
    checkOutput("l5Stream", chainModel, 36'h5_04_03_02_01);
`ifdef CCFF_LOADER_READBACK_EN
    checkOutput("l5RbCount", rbCount, 5);
`else
    checkOutput("l5RbNone", rbCount, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
